// File: rtl/ps2_byte_rx_pkg.sv
// rtl/ps2_byte_rx_pkg.sv - shared PS/2 receiver definitions
// State encodings, frame constants and scan-code values shared with the key decoder.
package ps2_byte_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int         PS2_DATA_BITS = 8;
    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-FF synchroniser plus run-length glitch filter
// The output follows the synchronised input only after FILTER_LEN consecutive differing samples.
module ps2_sync_filter #(
    parameter int   FILTER_LEN = 8,
    parameter logic RESET_VAL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int             CW   = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  LAST = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
            r_filt  <= RESET_VAL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the current output restarts the run.
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/ps2_byte_rx.sv
// rtl/ps2_byte_rx.sv - PS/2 device-to-host byte receiver
// Filters the pads, assembles 11-bit frames, checks parity/framing and aborts stalled frames.
module ps2_byte_rx
    import ps2_byte_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT = 3'(PS2_DATA_BITS - 1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;
    logic w_timeout;

    logic          r_clk_prev;
    ps2_state_t    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;

    ps2_state_t    w_state_next;
    logic [2:0]    w_bit_next;
    logic [7:0]    w_shift_next;
    logic          w_par_next;
    logic [7:0]    w_byte_next;
    logic          w_valid_next;
    logic          w_perr_next;
    logic          w_ferr_next;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN),
        .RESET_VAL  (1'b1)
    ) u_clk_filt (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (ps2_clk_in),
        .o_filt (w_clk_f)
    );

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN),
        .RESET_VAL  (1'b1)
    ) u_data_filt (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (ps2_data_in),
        .o_filt (w_data_f)
    );

    assign w_fall    = r_clk_prev & ~w_clk_f;
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_LAST);
    assign busy      = (r_state != ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_byte_next  = byte_data;
        w_valid_next = 1'b0;
        w_perr_next  = 1'b0;
        w_ferr_next  = 1'b0;
        // A fall takes priority over a timeout landing in the same cycle.
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_data_f) begin
                        w_state_next = ST_DATA;
                        w_bit_next   = 3'd0;
                    end else begin
                        w_ferr_next = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_shift_next = {w_data_f, r_shift[7:1]};
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = ST_PARITY;
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    w_par_next   = w_data_f;
                    w_state_next = ST_STOP;
                end
                ST_STOP: begin
                    if (!w_data_f) begin
                        w_ferr_next = 1'b1;
                    end else if (!ps2_parity_ok(r_shift, r_par)) begin
                        w_perr_next = 1'b1;
                    end else begin
                        w_byte_next  = r_shift;
                        w_valid_next = 1'b1;
                    end
                    w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_ferr_next  = 1'b1;
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_prev <= 1'b1;
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_par      <= 1'b0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_f;
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_par      <= w_par_next;
            byte_data  <= w_byte_next;
            byte_valid <= w_valid_next;
            parity_err <= w_perr_next;
            frame_err  <= w_ferr_next;
        end
    end

    // Stall counter: saturating so a long idle hold can never wrap back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (w_fall || (r_state == ST_IDLE)) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != {TW{1'b1}}) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_ps2_byte_rx.sv
// tb/tb_ps2_byte_rx.sv - self-checking bench for ps2_byte_rx
module tb_ps2_byte_rx;

    localparam int FL = 8;
    localparam int T  = 400;
    localparam int H  = 40;

    typedef enum int {K_VALID = 0, K_PERR = 1, K_FERR = 2} kind_t;

    typedef struct {
        logic [7:0] data;
        logic       par_good;
        logic       stop;
        kind_t      kind;
    } vec_t;

    typedef struct {
        kind_t      kind;
        logic [7:0] byte_val;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   ferr_cyc = 0;
    logic [7:0] model_byte = 8'h00;
    exp_t sb[$];
    vec_t vecs[9];

    ps2_byte_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .ps2_clk_in  (ps2_clk),
        .ps2_data_in (ps2_data),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input kind_t k, input logic [7:0] d);
        exp_t e;
        if (k == K_VALID) model_byte = d;
        e.kind     = k;
        e.byte_val = model_byte;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        if (glitch) begin
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (H/2 - 8) @(negedge clk);
        end else begin
            repeat (H/2) @(negedge clk);
        end
        ps2_data = b;
        repeat (H/2) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int glitch_idx);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch_idx == i);
        send_bit(p, 1'b0);
        send_bit(stop, 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i], 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (byte_valid || parity_err || frame_err)) begin
            kind_t k;
            exp_t  e;
            k = byte_valid ? K_VALID : (parity_err ? K_PERR : K_FERR);
            chk("one_flag", 32'(byte_valid) + 32'(parity_err) + 32'(frame_err), 1);
            chk("busy_at_flag", 32'(busy), 0);
            if (frame_err) ferr_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flag: got kind %0d, expected no flag", int'(k));
            end else begin
                e = sb.pop_front();
                chk("flag_kind", 32'(int'(k)), 32'(int'(e.kind)));
                chk("byte_data", 32'(byte_data), 32'(e.byte_val));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h1C, 1'b1, 1'b1, K_VALID};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, K_VALID};
        vecs[2] = '{8'h1C, 1'b1, 1'b1, K_VALID};
        vecs[3] = '{8'h1C, 1'b0, 1'b1, K_PERR};
        vecs[4] = '{8'h00, 1'b1, 1'b1, K_VALID};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, K_VALID};
        vecs[6] = '{8'hA5, 1'b1, 1'b0, K_FERR};
        vecs[7] = '{8'hE0, 1'b0, 1'b1, K_PERR};
        vecs[8] = '{8'h81, 1'b1, 1'b1, K_VALID};

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_byte_data", 32'(byte_data), 0);
        chk("reset_flags", {29'd0, byte_valid, parity_err, frame_err}, 0);
        chk("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // Table of back-to-back frames; parity bit derived from the good/bad flag.
        for (int i = 0; i < 9; i++) begin
            logic p;
            p = vecs[i].par_good ? ~^vecs[i].data : ^vecs[i].data;
            push(vecs[i].kind, vecs[i].data);
            send_frame(vecs[i].data, p, vecs[i].stop, -1);
        end
        repeat (50) @(negedge clk);

        // Lone clock pulse with data high is a bad start bit.
        push(K_FERR, 8'h00);
        send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        repeat (50) @(negedge clk);

        // Stall after five data bits.
        send_partial(8'h3B, 5);
        repeat (20) @(negedge clk);
        chk("busy_mid_frame", 32'(busy), 1);
        push(K_FERR, 8'h00);
        ferr_cyc = 0;
        repeat (T + 50) @(negedge clk);
        chk("timeout_latency", 32'(ferr_cyc - fall_cyc), 32'(3 + FL + T));
        ps2_data = 1'b1;
        push(K_VALID, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        repeat (50) @(negedge clk);

        // Short low glitch on the clock during data bit 2.
        push(K_VALID, 8'h29);
        send_frame(8'h29, 1'b0, 1'b1, 2);
        repeat (50) @(negedge clk);

        // Reset after bit 4 of a frame.
        send_partial(8'hC3, 5);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_byte_data", 32'(byte_data), 0);
        chk("midrst_flags", {29'd0, byte_valid, parity_err, frame_err}, 0);
        chk("midrst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n      = 1'b1;
        model_byte = 8'h00;
        ps2_data   = 1'b1;
        repeat (100) @(negedge clk);
        chk("postrst_busy", 32'(busy), 0);
        chk("postrst_byte_data", 32'(byte_data), 0);
        push(K_VALID, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, -1);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        chk("final_byte_data", 32'(byte_data), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
